// File: rtl/panel_input_reader.sv
// Front-panel switch/enter-button reader: sync, debounce, single-word holding register for the CPU.
// Optional macro PANEL_OVERRUN_DETECT_EN: keep first word and flag overrun instead of overwriting.
module panel_input_reader #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DATA_W          = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_in,
  input  logic              btn_n,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ack,
  output logic              full,
  output logic              overrun,
  output logic [1:0]        state_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_THR = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  logic              btn_s1_q, btn_s1_d;
  logic              btn_s2_q, btn_s2_d;
  logic              btn_prev_q, btn_prev_d;
  logic [DATA_W-1:0] sw_s1_q, sw_s1_d;
  logic [DATA_W-1:0] sw_s2_q, sw_s2_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              db_level_q, db_level_d;
  logic              armed_q, armed_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              btn_chg;
  logic              stable;
  logic              press;

  // cnt_q counts consecutive equal synchronized samples, including the current one.
  always_comb begin
    btn_s1_d   = btn_n;
    btn_s2_d   = btn_s1_q;
    btn_prev_d = btn_s2_q;
    sw_s1_d    = sw_in;
    sw_s2_d    = sw_s1_q;
    btn_chg    = (btn_s2_q != btn_prev_q);
    stable     = !btn_chg && (cnt_q >= CNT_THR);
    if (btn_chg) begin
      cnt_d = CW'(1);
    end else if (cnt_q < CNT_SAT) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    db_level_d = stable ? btn_s2_q : db_level_q;
    // A press only counts once a clean release has been seen since reset.
    armed_d    = armed_q | (stable & btn_s2_q);
    press      = armed_q & stable & db_level_q & ~btn_s2_q;
  end

`ifdef PANEL_OVERRUN_DETECT_EN
  logic ovr_q, ovr_d;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
`ifdef PANEL_OVERRUN_DETECT_EN
    ovr_d   = ovr_q;
`endif
    case (state_q)
      ST_EMPTY: begin
        if (press) begin
          hold_d  = sw_s2_q;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (press) begin
`ifdef PANEL_OVERRUN_DETECT_EN
          ovr_d  = 1'b1;
`else
          hold_d = sw_s2_q;
`endif
        end
        if (rd_req) state_d = ST_ACK;
      end
      ST_ACK: begin
`ifdef PANEL_OVERRUN_DETECT_EN
        ovr_d = 1'b0;
`endif
        if (press) begin
          hold_d  = sw_s2_q;
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_s1_q   <= 1'b1;
      btn_s2_q   <= 1'b1;
      btn_prev_q <= 1'b1;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      cnt_q      <= '0;
      db_level_q <= 1'b1;
      armed_q    <= 1'b0;
      state_q    <= ST_EMPTY;
      hold_q     <= '0;
    end else begin
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_prev_q <= btn_prev_d;
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      cnt_q      <= cnt_d;
      db_level_q <= db_level_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
    end
  end

`ifdef PANEL_OVERRUN_DETECT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ovr_q <= 1'b0;
    else        ovr_q <= ovr_d;
  end
  assign overrun = ovr_q;
`else
  assign overrun = 1'b0;
`endif

  assign rd_ack    = (state_q == ST_ACK);
  assign full      = (state_q == ST_FULL) || (state_q == ST_ACK);
  assign rd_data   = hold_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_panel_input_reader.sv
// Directed bench for panel_input_reader with a transaction-level holding-register model.
module tb_panel_input_reader;

  logic        clock;
  logic        reset;
  logic [15:0] sw_in;
  logic        btn_n;
  logic        rd_req;
  logic [15:0] rd_data;
  logic        rd_ack;
  logic        full;
  logic        overrun;
  logic [1:0]  state_out;

  panel_input_reader #(.DEBOUNCE_CYCLES(4), .DATA_W(16)) dut (
    .clock(clock), .reset(reset), .sw_in(sw_in), .btn_n(btn_n), .rd_req(rd_req),
    .rd_data(rd_data), .rd_ack(rd_ack), .full(full), .overrun(overrun), .state_out(state_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int rise_cnt = 0;
  logic prev_full = 1'b0;

  // Model: a single-word mailbox, valid only when no transaction is in flight.
  bit          m_valid = 1'b0;
  logic        m_full = 1'b0;
  logic [15:0] m_data = '0;
  logic        m_overrun = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic model_press(input logic [15:0] w);
    if (!m_full) begin
      m_full = 1'b1;
      m_data = w;
    end else begin
`ifdef PANEL_OVERRUN_DETECT_EN
      m_overrun = 1'b1;
`else
      m_data = w;
`endif
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_data = '0;
    m_overrun = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        if (full && !prev_full) rise_cnt++;
        prev_full = full;
        if (m_valid) begin
          chk("cmp_full", full, m_full);
          chk("cmp_rd_data", rd_data, m_data);
          chk("cmp_overrun", overrun, m_overrun);
          chk("cmp_state", state_out, m_full ? 2 : 0);
          chk("cmp_rd_ack", rd_ack, 0);
        end
      end else begin
        prev_full = 1'b0;
      end
    end
  end

  task automatic do_press(input logic [15:0] w, input int glitches);
    int  r0;
    bit  exp_cap;
    m_valid = 1'b0;
    exp_cap = !m_full;
    r0 = rise_cnt;
    sw_in = w;
    cyc(3);
    repeat (glitches) begin
      btn_n = 1'b0;
      cyc(1);
      btn_n = 1'b1;
      cyc(2);
    end
    btn_n = 1'b0;
    cyc(10);
    btn_n = 1'b1;
    cyc(10);
    model_press(w);
    chk("press_captures", rise_cnt - r0, exp_cap ? 1 : 0);
    m_valid = 1'b1;
  endtask

  task automatic wait_ack(output bit got, output int full_cycles);
    int waited;
    got = 1'b0;
    waited = 0;
    full_cycles = 0;
    while (!got && waited < 60) begin
      @(negedge clock);
      if (rd_ack) got = 1'b1;
      else begin
        if (full) full_cycles++;
        waited++;
      end
    end
  endtask

  task automatic do_read();
    bit got;
    int fc;
    m_valid = 1'b0;
    rd_req = 1'b1;
    wait_ack(got, fc);
    chk("ack_seen", got, 1);
    if (got) begin
      chk("ack_data", rd_data, m_data);
      chk("ack_full", full, 1);
      chk("ack_state", state_out, 2);
    end
    @(posedge clock);
    #1;
    rd_req = 1'b0;
    m_full = 1'b0;
    m_overrun = 1'b0;
    m_valid = 1'b1;
  endtask

  initial begin
    bit got;
    int fc;
    reset = 1'b0;
    sw_in = 16'hA5A5;
    btn_n = 1'b0;
    rd_req = 1'b0;

    // Reset with the button held down
    cyc(3);
    @(negedge clock);
    chk("rst_rd_data", rd_data, 16'h0000);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_full", full, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_state", state_out, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    m_valid = 1'b1;
    cyc(20);
    btn_n = 1'b1;
    cyc(10);

    // Bouncy press, then a read
    do_press(16'h1234, 3);
    chk("cap_full", full, 1);
    chk("cap_data", rd_data, 16'h1234);
    do_read();
    @(negedge clock);
    chk("post_read_full", full, 0);
    chk("post_read_state", state_out, 0);
    chk("post_read_data", rd_data, 16'h1234);
    cyc(1);

    // Processor stalls on an empty register
    m_valid = 1'b0;
    rd_req = 1'b1;
    repeat (20) begin
      @(negedge clock);
      chk("stall_no_ack", rd_ack, 0);
      chk("stall_state", state_out, 0);
    end
    cyc(1);
    sw_in = 16'h00FF;
    cyc(3);
    btn_n = 1'b0;
    wait_ack(got, fc);
    chk("stall_ack_seen", got, 1);
    chk("stall_ack_data", rd_data, 16'h00FF);
    chk("full_before_ack", fc, 1);
    @(posedge clock);
    #1;
    rd_req = 1'b0;
    cyc(6);
    btn_n = 1'b1;
    cyc(10);
    m_full = 1'b0;
    m_data = 16'h00FF;
    m_valid = 1'b1;

    // Second press while holding an unread word
    do_press(16'h0001, 0);
    do_press(16'h0002, 1);
`ifdef PANEL_OVERRUN_DETECT_EN
    chk("two_press_data", rd_data, 16'h0001);
    chk("two_press_ovr", overrun, 1);
`else
    chk("two_press_data", rd_data, 16'h0002);
    chk("two_press_ovr", overrun, 0);
`endif
    do_read();
    cyc(2);
    chk("ovr_cleared", overrun, 0);

    // Reset asserted in the middle of an ACK cycle
    do_press(16'h5A5A, 0);
    m_valid = 1'b0;
    rd_req = 1'b1;
    wait_ack(got, fc);
    chk("rst_ack_seen", got, 1);
    reset = 1'b0;
    #1;
    chk("rst_ack_drop", rd_ack, 0);
    chk("rst_ack_full", full, 0);
    chk("rst_ack_data", rd_data, 16'h0000);
    chk("rst_ack_state", state_out, 0);
    rd_req = 1'b0;
    cyc(2);
    reset = 1'b1;
    model_reset();
    m_valid = 1'b1;
    cyc(10);

    // Reset in the middle of debouncing a press
    sw_in = 16'h7777;
    btn_n = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    btn_n = 1'b1;
    cyc(1);
    reset = 1'b1;
    cyc(12);
    chk("mid_db_full", full, 0);

    do_press(16'hC3C3, 1);
    do_read();
    cyc(2);
    chk("data_held", rd_data, 16'hC3C3);

    m_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/panel_input_reader.md
PANEL_INPUT_READER -- requirements
Module: panel_input_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a new button level.
REQ-002 SHALL have parameter DATA_W, default 16, width of the switch word.
REQ-003 SHALL have port clock, input, 1, single clock for all logic.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-005 SHALL have port sw_in, input, DATA_W, raw panel switch word, asynchronous.
REQ-006 SHALL have port btn_n, input, 1, raw enter push-button, active-low, asynchronous, bouncing.
REQ-007 SHALL have port rd_req, input, 1, processor read request, level, held until rd_ack.
REQ-008 SHALL have port rd_data, output, DATA_W, captured word delivered to the processor.
REQ-009 SHALL have port rd_ack, output, 1, one-cycle read acknowledge.
REQ-010 SHALL have port full, output, 1, holding register contains an unread word.
REQ-011 SHALL have port overrun, output, 1, sticky flag, press arrived while full (see Configuration).
REQ-012 SHALL have port state_out, output, 2, current FSM state for panel display.

Function
REQ-013 SHALL pass btn_n and sw_in each through a 2-flop synchronizer before any use.
REQ-014 SHALL debounce the synchronized button: counter reloads on any level change, and debounced level updates only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-015 SHALL generate press pulse on the debounced 1->0 transition only; release generates nothing.
REQ-016 SHALL implement FSM states EMPTY(0), FULL(1), ACK(2); encoding 3 unused, recovers to EMPTY next cycle.
REQ-017 EMPTY: press -> latch synchronized sw_in into holding register, go FULL next cycle.
REQ-018 FULL: rd_req=1 -> go ACK; press while FULL -> holding register unchanged, overrun set.
REQ-019 ACK: rd_ack=1 for exactly this one cycle, rd_data=holding register; next state EMPTY.
REQ-020 EMPTY with rd_req=1 SHALL keep rd_ack=0 (processor stalls until a word arrives).
REQ-021 Press and rd_req in same cycle while EMPTY SHALL capture first; ack occurs no earlier than 2 cycles later.
REQ-022 Press in ACK cycle SHALL be captured: next state FULL with new word instead of EMPTY.
REQ-023 full SHALL be 1 in FULL and ACK, 0 otherwise.
REQ-024 rd_data SHALL hold the last captured word at all times (not zeroed after ack).
REQ-025 Debounce counter SHALL saturate, never wrap; width ceil(log2(DEBOUNCE_CYCLES+1)).

Reset
REQ-026 reset=0 SHALL immediately force: state EMPTY, rd_data=0, rd_ack=0, full=0, overrun=0, debounced level=1 (released), counter=0, synchronizers=1 for button, 0 for switches.
REQ-027 Reset mid-debounce or mid-ACK SHALL discard pending press/word; button held through reset release SHALL NOT produce a press until released and pressed again.

Configuration
REQ-028 Macro PANEL_OVERRUN_DETECT_EN defined: overrun sets per REQ-018 and clears only on reset or an acknowledged read (ACK state).
REQ-029 Macro undefined: overrun tied 0; press while FULL overwrites holding register with new sw_in, state stays FULL.

Verification (DEBOUNCE_CYCLES=4 on bench)
REQ-030 Reset low, sw_in=16'hA5A5, btn_n=0 -> all outputs 0, state_out=0; after reset release no press until btn_n 1 then 0.
REQ-031 sw_in=16'h1234, btn_n low 10 cycles with 3 bounce glitches first -> single capture, full=1, rd_data=16'h1234.
REQ-032 FULL, rd_req=1 -> rd_ack one cycle, rd_data=16'h1234, then full=0, state EMPTY.
REQ-033 rd_req=1 while EMPTY 20 cycles, then press sw_in=16'h00FF -> rd_ack only after capture, data 16'h00FF.
REQ-034 Two presses (16'h0001, 16'h0002) without read -> with macro: rd_data=16'h0001, overrun=1, cleared on ack; without macro: rd_data=16'h0002, overrun=0.
REQ-035 Reset asserted during ACK -> rd_ack drops same cycle asynchronously, full=0, rd_data=0.
